// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, line levels
// and a counter-width helper.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LINE = 1'b1;

  // A 1-bit data field still needs a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator shared by the TX and RX paths.
// par_typ=0 gives even parity (^data), par_typ=1 gives odd parity (~^data).
module uart_parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  // Seeding the xor chain with par_typ inverts the result for odd parity.
  logic [DATA_WIDTH:0] chain;

  assign chain[0] = par_typ;

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_xor
    assign chain[gi+1] = chain[gi] ^ data[gi];
  end

  assign parity = chain[DATA_WIDTH];

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Drains a FIFO read port one word at a time and serialises each word as a
// UART frame (start, data LSB first, optional parity, stop), one bit per clk.
module uart_tx_fifo_drain
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  fifo_r_inc,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  par_bit_reg;
  logic                  par_en_reg;
  logic                  tx_out_reg;
  logic                  busy_reg;
  logic                  r_inc_reg;
  logic                  parity_next;

  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data   (fifo_rd_data),
    .par_typ(par_typ),
    .parity (parity_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      data_reg    <= '0;
      par_bit_reg <= 1'b0;
      par_en_reg  <= 1'b0;
      tx_out_reg  <= IDLE_LINE;
      busy_reg    <= 1'b0;
      r_inc_reg   <= 1'b0;
    end else begin
      r_inc_reg <= 1'b0;
      case (state_reg)
        // IDLE and the end of STOP make the same decision: start the next
        // word immediately if one is waiting, otherwise rest the line.
        ST_IDLE, ST_STOP: begin
          if (!fifo_empty) begin
            data_reg    <= fifo_rd_data;
            par_bit_reg <= parity_next;
            par_en_reg  <= par_en;
            r_inc_reg   <= 1'b1;
            busy_reg    <= 1'b1;
            tx_out_reg  <= START_BIT;
            state_reg   <= ST_START;
          end else begin
            busy_reg   <= 1'b0;
            tx_out_reg <= IDLE_LINE;
            state_reg  <= ST_IDLE;
          end
        end
        ST_START: begin
          cnt_reg    <= '0;
          tx_out_reg <= data_reg[0];
          data_reg   <= data_reg >> 1;
          state_reg  <= ST_DATA;
        end
        ST_DATA: begin
          if (cnt_reg == CNT_LAST) begin
            if (par_en_reg) begin
              tx_out_reg <= par_bit_reg;
              state_reg  <= ST_PARITY;
            end else begin
              tx_out_reg <= STOP_BIT;
              state_reg  <= ST_STOP;
            end
          end else begin
            // The shift register always presents the next bit at position 0.
            cnt_reg    <= cnt_reg + 1'b1;
            tx_out_reg <= data_reg[0];
            data_reg   <= data_reg >> 1;
          end
        end
        ST_PARITY: begin
          tx_out_reg <= STOP_BIT;
          state_reg  <= ST_STOP;
        end
        default: begin
          busy_reg   <= 1'b0;
          tx_out_reg <= IDLE_LINE;
          state_reg  <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifo_r_inc = r_inc_reg;
  assign tx_out     = tx_out_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Randomised self-checking bench: a queue-based FIFO feeds the DUT and a
// frame-level model predicts tx_out/busy/fifo_r_inc for every cycle.
module tb_uart_tx_fifo_drain;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          par_en;
  logic          par_typ;
  logic          fifo_r_inc;
  logic          tx_out;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_q[$];
  logic          pop_pending;
  logic          exp_tx[$];
  logic          exp_busy[$];
  logic          exp_inc[$];

  uart_tx_fifo_drain #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .par_en      (par_en),
    .par_typ     (par_typ),
    .fifo_r_inc  (fifo_r_inc),
    .tx_out      (tx_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Frame model: start bit, data LSB first, parity from the count of ones, stop bit.
  task automatic add_frame(input logic [DW-1:0] w, input logic pe, input logic pt);
    logic odd_ones;
    exp_tx.push_back(1'b0); exp_busy.push_back(1'b1); exp_inc.push_back(1'b1);
    for (int b = 0; b < DW; b++) begin
      exp_tx.push_back(w[b]); exp_busy.push_back(1'b1); exp_inc.push_back(1'b0);
    end
    if (pe) begin
      odd_ones = (($countones(w) % 2) == 1);
      exp_tx.push_back(odd_ones != pt); exp_busy.push_back(1'b1); exp_inc.push_back(1'b0);
    end
    exp_tx.push_back(1'b1); exp_busy.push_back(1'b1); exp_inc.push_back(1'b0);
  endtask

  task automatic add_idle(input int n);
    for (int k = 0; k < n; k++) begin
      exp_tx.push_back(1'b1); exp_busy.push_back(1'b0); exp_inc.push_back(1'b0);
    end
  endtask

  task automatic fifo_present();
    if (fifo_q.size() > 0) begin
      fifo_empty   = 1'b0;
      fifo_rd_data = fifo_q[0];
    end else begin
      fifo_empty   = 1'b1;
      fifo_rd_data = DW'($urandom);
    end
  endtask

  // Plays the FIFO against the DUT and compares every cycle with the model.
  task automatic run_expected(input string name, input int perturb_cycle,
                              input int late_cycle, input logic [DW-1:0] late_word);
    pop_pending = 1'b0;
    fifo_present();
    for (int i = 0; i < exp_tx.size(); i++) begin
      @(posedge clk);
      #1;
      if (pop_pending && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        fifo_present();
      end
      if (i == late_cycle) begin
        fifo_q.push_back(late_word);
        fifo_present();
      end
      checks++;
      if (tx_out !== exp_tx[i]) begin
        errors++;
        $display("FAIL %s cyc %0d tx_out got %b want %b", name, i, tx_out, exp_tx[i]);
      end
      checks++;
      if (busy !== exp_busy[i]) begin
        errors++;
        $display("FAIL %s cyc %0d busy got %b want %b", name, i, busy, exp_busy[i]);
      end
      checks++;
      if (fifo_r_inc !== exp_inc[i]) begin
        errors++;
        $display("FAIL %s cyc %0d fifo_r_inc got %b want %b", name, i, fifo_r_inc, exp_inc[i]);
      end
      if (i == perturb_cycle) begin
        par_en       = !par_en;
        par_typ      = !par_typ;
        fifo_rd_data = ~fifo_rd_data;
      end
      pop_pending = fifo_r_inc;
    end
    $display("%s: %0d cycles compared", name, exp_tx.size());
    exp_tx.delete(); exp_busy.delete(); exp_inc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; fifo_empty = 1'b1; fifo_rd_data = '0; par_en = 1'b0; par_typ = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || fifo_r_inc !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got tx=%b busy=%b inc=%b want 1 0 0", tx_out, busy, fifo_r_inc);
    end
    rst = 1'b0;
    add_idle(50);
    run_expected("reset_idle", -1, -1, '0);
  endtask

  task automatic test_single();
    par_en = 1'b0; par_typ = 1'b0;
    fifo_q.push_back(8'hA5);
    add_frame(8'hA5, 1'b0, 1'b0);
    add_idle(4);
    run_expected("single_a5", -1, -1, '0);
  endtask

  task automatic test_parity();
    for (int pt = 0; pt < 2; pt++) begin
      par_en = 1'b1; par_typ = pt[0];
      fifo_q.push_back(8'hA5);
      add_frame(8'hA5, 1'b1, pt[0]);
      add_idle(3);
      run_expected(pt == 0 ? "parity_even" : "parity_odd", -1, -1, '0);
    end
    par_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    par_en = 1'b0; par_typ = 1'b0;
    fifo_q.push_back(8'h01); fifo_q.push_back(8'h80); fifo_q.push_back(8'hFF);
    add_frame(8'h01, 1'b0, 1'b0);
    add_frame(8'h80, 1'b0, 1'b0);
    add_frame(8'hFF, 1'b0, 1'b0);
    add_idle(5);
    run_expected("back_to_back", -1, -1, '0);
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] w;
    w = 8'h3C;
    par_en = 1'b0;
    fifo_q.push_back(w);
    pop_pending = 1'b0;
    fifo_present();
    // Cycle 0 is the start bit, so data bit 3 is on the line at cycle 4.
    for (int i = 0; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if (pop_pending && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        fifo_present();
      end
      pop_pending = fifo_r_inc;
    end
    checks++;
    if (busy !== 1'b1 || tx_out !== w[3]) begin
      errors++;
      $display("FAIL mid_reset_pre got busy=%b tx=%b want 1 %b", busy, tx_out, w[3]);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || fifo_r_inc !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async got tx=%b busy=%b inc=%b want 1 0 0", tx_out, busy, fifo_r_inc);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    fifo_q.delete();
    add_idle(20);
    run_expected("after_mid_reset", -1, -1, '0);
  endtask

  task automatic test_mid_frame_changes();
    logic [DW-1:0] w;
    logic          pt;
    w = DW'($urandom); pt = 1'($urandom);
    par_en = 1'b0; par_typ = pt;
    fifo_q.push_back(w);
    add_frame(w, 1'b0, pt);
    add_idle(3);
    run_expected("mid_frame_changes", 3, -1, '0);
    par_en = 1'b0;
  endtask

  task automatic test_late_word();
    logic [DW-1:0] w1, w2;
    w1 = DW'($urandom); w2 = DW'($urandom);
    par_en = 1'b1; par_typ = 1'b1;
    fifo_q.push_back(w1);
    add_frame(w1, 1'b1, 1'b1);
    add_frame(w2, 1'b1, 1'b1);
    add_idle(3);
    run_expected("late_word", -1, 5, w2);
    par_en = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int            n;
      logic          pe, pt;
      logic [DW-1:0] w;
      n = $urandom_range(1, 4);
      pe = 1'($urandom); pt = 1'($urandom);
      par_en = pe; par_typ = pt;
      for (int k = 0; k < n; k++) begin
        w = DW'($urandom);
        fifo_q.push_back(w);
        add_frame(w, pe, pt);
      end
      add_idle($urandom_range(2, 4));
      run_expected("random", -1, -1, '0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_mid_frame_changes();
    test_late_word();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
